// File: rtl/painterengine_gpu_blend_writeback.sv
// rtl/painterengine_gpu_blend_writeback.sv - blended-pixel sink: ARGB pack, FIFO buffer, addressed write beats
//
// Purpose: accepts one job of N blended pixels, buffers them and emits
// address/data write beats toward the framebuffer writer, then pulses done.
//
// Ports:
//   i_wire_clock         clock, all logic on the rising edge
//   i_wire_resetn        synchronous active-low reset
//   i_wire_start         one-cycle job start (honoured only when idle)
//   i_wire_base_address  byte address of the first pixel
//   i_wire_pixel_count   pixels in the job
//   i_wire_valid, a/r/g/b  blended pixel input (no backpressure)
//   o_wire_valid, i_wire_ready, o_wire_address, o_wire_data  write beat handshake
//   o_wire_busy          job in progress
//   o_wire_done          one-cycle completion pulse
//   o_wire_overflow      sticky: a pixel was dropped on a full FIFO
module painterengine_gpu_blend_writeback #(
    parameter int FIFO_DEPTH  = 16,
    parameter int COUNT_WIDTH = 24
) (
    input  logic                   i_wire_clock,
    input  logic                   i_wire_resetn,
    input  logic                   i_wire_start,
    input  logic [31:0]            i_wire_base_address,
    input  logic [COUNT_WIDTH-1:0] i_wire_pixel_count,
    input  logic                   i_wire_valid,
    input  logic [7:0]             a,
    input  logic [7:0]             r,
    input  logic [7:0]             g,
    input  logic [7:0]             b,
    output logic                   o_wire_valid,
    input  logic                   i_wire_ready,
    output logic [31:0]            o_wire_address,
    output logic [31:0]            o_wire_data,
    output logic                   o_wire_busy,
    output logic                   o_wire_done,
    output logic                   o_wire_overflow
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int DEPTH_W = PTR_W + 1;
    localparam logic [DEPTH_W-1:0]     LP_FULL    = DEPTH_W'(FIFO_DEPTH);
    localparam logic [DEPTH_W-1:0]     LP_D_ONE   = DEPTH_W'(1);
    localparam logic [PTR_W-1:0]       LP_P_ONE   = PTR_W'(1);
    localparam logic [COUNT_WIDTH-1:0] LP_C_ONE   = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FINISH
    } state_t;

    state_t                 r_state;
    logic [31:0]            r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [DEPTH_W-1:0]     r_depth;
    logic [31:0]            r_base;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] r_accepted;
    logic [COUNT_WIDTH-1:0] r_written;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_overflow;

    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_take;
    logic                   w_push;
    logic                   w_drop;
    logic [COUNT_WIDTH-1:0] w_accepted_next;
    logic [31:0]            w_written_ext;
    logic [31:0]            w_pixel;

    assign w_empty = (r_depth == '0);
    assign w_full  = (r_depth == LP_FULL);

    // The FIFO is always empty in IDLE, so gating with the state only guards
    // against a stray ready while nothing is owned by a job.
    assign w_pop  = (r_state != ST_IDLE) && !w_empty && i_wire_ready;

    // Every pixel up to the job count is "accepted", even if it is dropped;
    // a same-cycle pop frees the slot a full FIFO would otherwise refuse.
    assign w_take = (r_state == ST_RUN) && i_wire_valid && (r_accepted < r_count);
    assign w_push = w_take && (!w_full || w_pop);
    assign w_drop = w_take && !w_push;

    assign w_accepted_next = w_take ? (r_accepted + LP_C_ONE) : r_accepted;
    assign w_written_ext   = 32'(r_written);
    assign w_pixel         = {a, r, g, b};

    assign o_wire_valid    = !w_empty;
    assign o_wire_data     = w_empty ? 32'd0 : r_mem[r_rd_ptr];
    assign o_wire_address  = r_base + (w_written_ext << 2);
    assign o_wire_busy     = r_busy;
    assign o_wire_done     = r_done;
    assign o_wire_overflow = r_overflow;

    // Storage needs no reset: validity is tracked entirely by r_depth.
    always_ff @(posedge i_wire_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_pixel;
        end
    end

    always_ff @(posedge i_wire_clock) begin
        if (!i_wire_resetn) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_depth    <= '0;
            r_base     <= '0;
            r_count    <= '0;
            r_accepted <= '0;
            r_written  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_accepted <= w_accepted_next;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LP_P_ONE;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + LP_P_ONE;
                r_written <= r_written + LP_C_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_depth <= r_depth + LP_D_ONE;
                2'b01:   r_depth <= r_depth - LP_D_ONE;
                default: r_depth <= r_depth;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    // r_done high means this is the completion cycle; a start
                    // landing on it belongs to nobody and is dropped.
                    if (i_wire_start && !r_done) begin
                        r_base     <= i_wire_base_address;
                        r_count    <= i_wire_pixel_count;
                        r_accepted <= '0;
                        r_written  <= '0;
                        r_overflow <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= (i_wire_pixel_count == '0) ? ST_FINISH : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_accepted_next == r_count) begin
                        r_state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    if (w_empty) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_painterengine_gpu_blend_writeback.sv
// tb/tb_painterengine_gpu_blend_writeback.sv - randomized self-checking bench with queue reference model
module tb_painterengine_gpu_blend_writeback;

    localparam int DEPTH = 16;
    localparam int CW    = 24;

    logic          clk = 1'b0;
    logic          resetn;
    logic          tb_start;
    logic [31:0]   tb_base;
    logic [CW-1:0] tb_count;
    logic          tb_vin;
    logic [31:0]   tb_px;
    logic          tb_ready;
    logic          o_valid;
    logic [31:0]   o_addr;
    logic [31:0]   o_data;
    logic          o_busy;
    logic          o_done;
    logic          o_ovf;

    always #5 clk = ~clk;

    painterengine_gpu_blend_writeback #(
        .FIFO_DEPTH  (DEPTH),
        .COUNT_WIDTH (CW)
    ) dut (
        .i_wire_clock        (clk),
        .i_wire_resetn       (resetn),
        .i_wire_start        (tb_start),
        .i_wire_base_address (tb_base),
        .i_wire_pixel_count  (tb_count),
        .i_wire_valid        (tb_vin),
        .a                   (tb_px[31:24]),
        .r                   (tb_px[23:16]),
        .g                   (tb_px[15:8]),
        .b                   (tb_px[7:0]),
        .o_wire_valid        (o_valid),
        .i_wire_ready        (tb_ready),
        .o_wire_address      (o_addr),
        .o_wire_data         (o_data),
        .o_wire_busy         (o_busy),
        .o_wire_done         (o_done),
        .o_wire_overflow     (o_ovf)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a job is "active" from the accepted start until done;
    // the buffered pixels are simply a queue bounded by DEPTH.
    bit          m_active;
    bit          m_all_acc;
    bit          m_done;
    bit          m_ovf;
    logic [31:0] m_base;
    int          m_count;
    int          m_acc;
    int          m_written;
    int          m_beats;
    logic [31:0] m_q[$];

    logic [31:0] pix_q[$];
    logic [31:0] beat_data[$];
    logic [31:0] beat_addr[$];

    task automatic model_reset();
        m_active = 0; m_all_acc = 0; m_done = 0; m_ovf = 0;
        m_base = '0; m_count = 0; m_acc = 0; m_written = 0; m_beats = 0;
        m_q.delete();
    endtask

    task automatic run_job(input logic [31:0] base, input int count, input int stall,
                           input int ready_pct, input int valid_pct, input int start_noise);
        int          cyc;
        bit          started;
        bit          fin;
        bit          st;
        bit          rdy;
        bit          vin;
        bit          pop;
        bit          nd;
        int          qs;
        logic [31:0] px;
        logic [31:0] exp_addr;
        cyc = 0; started = 0; fin = 0; m_beats = 0;
        beat_data.delete(); beat_addr.delete();
        while (!fin) begin
            n_tests++;
            if (o_valid !== (m_q.size() > 0)) begin
                n_fail++;
                $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, o_valid, m_q.size() > 0);
            end
            if (m_q.size() > 0) begin
                n_tests++;
                if (o_data !== m_q[0]) begin
                    n_fail++;
                    $display("FAIL data cyc=%0d got=%h exp=%h", cyc, o_data, m_q[0]);
                end
            end
            if (m_active) begin
                exp_addr = m_base + 32'(m_written * 4);
                n_tests++;
                if (o_addr !== exp_addr) begin
                    n_fail++;
                    $display("FAIL address cyc=%0d got=%h exp=%h", cyc, o_addr, exp_addr);
                end
            end
            n_tests++;
            if (o_busy !== m_active) begin
                n_fail++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, o_busy, m_active);
            end
            n_tests++;
            if (o_done !== m_done) begin
                n_fail++;
                $display("FAIL done cyc=%0d got=%b exp=%b", cyc, o_done, m_done);
            end
            n_tests++;
            if (o_ovf !== m_ovf) begin
                n_fail++;
                $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, o_ovf, m_ovf);
            end
            if (started && m_done) begin
                fin = 1;
            end else if (cyc > 3000) begin
                n_tests++; n_fail++;
                $display("FAIL timeout job base=%h count=%0d got=no_done exp=done", base, count);
                fin = 1;
            end else begin
                st  = !started ? 1'b1 : ($urandom_range(99) < start_noise);
                rdy = (cyc < stall) ? 1'b0 : ($urandom_range(99) < ready_pct);
                vin = started ? (pix_q.size() > 0 && $urandom_range(99) < valid_pct)
                              : ($urandom_range(1) == 1);
                px  = (vin && started) ? pix_q.pop_front() : $urandom();
                if (o_valid && rdy) begin
                    beat_data.push_back(o_data);
                    beat_addr.push_back(o_addr);
                end
                tb_start = st; tb_base = base; tb_count = CW'(count);
                tb_vin = vin; tb_px = px; tb_ready = rdy;

                qs  = m_q.size();
                pop = m_active && qs > 0 && rdy;
                nd  = 0;
                if (!m_active) begin
                    if (st && !m_done) begin
                        m_base = base; m_count = count; m_acc = 0; m_written = 0;
                        m_ovf = 0; m_active = 1; m_all_acc = (count == 0);
                    end
                end else begin
                    if (pop) begin
                        void'(m_q.pop_front());
                        m_written++;
                        m_beats++;
                    end
                    if (!m_all_acc) begin
                        if (vin && m_acc < m_count) begin
                            m_acc++;
                            if (qs < DEPTH || pop) m_q.push_back(px);
                            else m_ovf = 1;
                        end
                        if (m_acc == m_count) m_all_acc = 1;
                    end else if (qs == 0) begin
                        nd = 1;
                        m_active = 0;
                    end
                end
                m_done = nd;
                if (m_active) started = 1;

                @(posedge clk); #1;
                cyc++;
            end
        end
        tb_start = 0; tb_vin = 0;
        pix_q.delete();
        n_tests++;
        if (beat_data.size() != m_beats) begin
            n_fail++;
            $display("FAIL beat_count got=%0d exp=%0d", beat_data.size(), m_beats);
        end
    endtask

    task automatic test_reset();
        resetn = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        n_tests++; if (o_busy  !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        n_tests++; if (o_done  !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", o_done); end
        n_tests++; if (o_ovf   !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", o_ovf); end
        n_tests++; if (o_addr  !== 32'd0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", o_addr); end
        n_tests++; if (o_data  !== 32'd0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", o_data); end
        resetn = 1;
    endtask

    task automatic check_plan_beats(input string name, input logic [31:0] ed [], input logic [31:0] ea []);
        n_tests++;
        if (beat_data.size() != ed.size()) begin
            n_fail++;
            $display("FAIL %s_beats got=%0d exp=%0d", name, beat_data.size(), ed.size());
        end
        for (int i = 0; i < ed.size() && i < beat_data.size(); i++) begin
            n_tests++;
            if (beat_data[i] !== ed[i] || beat_addr[i] !== ea[i]) begin
                n_fail++;
                $display("FAIL %s_beat%0d got=%h@%h exp=%h@%h", name, i, beat_data[i], beat_addr[i], ed[i], ea[i]);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] ed [] = '{32'h80C0801C, 32'h80574437, 32'h40404040};
        logic [31:0] ea [] = '{32'h1000, 32'h1004, 32'h1008};
        pix_q = '{32'h80C0801C, 32'h80574437, 32'h40404040};
        run_job(32'h1000, 3, 0, 100, 100, 0);
        check_plan_beats("basic", ed, ea);
    endtask

    task automatic test_backpressure();
        logic [31:0] ed [] = '{32'h80C0801C, 32'h80574437, 32'h40404040};
        logic [31:0] ea [] = '{32'h1000, 32'h1004, 32'h1008};
        pix_q = '{32'h80C0801C, 32'h80574437, 32'h40404040};
        run_job(32'h1000, 3, 5, 100, 100, 0);
        check_plan_beats("backpressure", ed, ea);
    endtask

    task automatic test_overflow();
        logic [31:0] ed [];
        logic [31:0] ea [];
        ed = new[16]; ea = new[16];
        for (int i = 0; i < 20; i++) pix_q.push_back(32'hA5000000 | 32'(i));
        for (int i = 0; i < 16; i++) begin ed[i] = 32'hA5000000 | 32'(i); ea[i] = 32'(i * 4); end
        run_job(32'h0, 20, 22, 100, 100, 0);
        check_plan_beats("overflow", ed, ea);
        @(posedge clk); #1;
        n_tests++;
        if (o_ovf !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky got=%b exp=1", o_ovf); end
        m_done = 0;
    endtask

    task automatic test_zero_and_extra();
        logic [31:0] ed [] = '{32'h11223344, 32'h55667788};
        logic [31:0] ea [] = '{32'h400, 32'h404};
        run_job(32'h500, 0, 0, 100, 100, 0);
        n_tests++;
        if (beat_data.size() != 0) begin n_fail++; $display("FAIL zero_count_beats got=%0d exp=0", beat_data.size()); end
        pix_q = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
        run_job(32'h400, 2, 0, 100, 100, 0);
        check_plan_beats("extra", ed, ea);
    endtask

    task automatic test_addr_wrap();
        logic [31:0] ed [] = '{32'h01020304, 32'h05060708};
        logic [31:0] ea [] = '{32'hFFFFFFFC, 32'h00000000};
        pix_q = '{32'h01020304, 32'h05060708};
        run_job(32'hFFFFFFFC, 2, 0, 100, 100, 0);
        check_plan_beats("wrap", ed, ea);
    endtask

    task automatic test_reset_mid_job();
        logic [31:0] ed [] = '{32'hCAFEF00D};
        logic [31:0] ea [] = '{32'h3000};
        @(posedge clk); #1;
        tb_start = 1; tb_base = 32'h2000; tb_count = CW'(5); tb_ready = 0; tb_vin = 0;
        @(posedge clk); #1;
        tb_start = 0; tb_vin = 1; tb_px = 32'h12345678;
        @(posedge clk); #1;
        tb_px = 32'h9ABCDEF0;
        @(posedge clk); #1;
        tb_vin = 0;
        n_tests++;
        if (o_busy !== 1'b1 || o_valid !== 1'b1) begin
            n_fail++; $display("FAIL midjob_active got=busy%b/valid%b exp=busy1/valid1", o_busy, o_valid);
        end
        resetn = 0;
        @(posedge clk); #1;
        n_tests++;
        if ({o_valid, o_busy, o_done, o_ovf} !== 4'b0 || o_addr !== 32'd0 || o_data !== 32'd0) begin
            n_fail++;
            $display("FAIL midjob_reset got=v%b b%b d%b o%b a=%h d=%h exp=all_zero", o_valid, o_busy, o_done, o_ovf, o_addr, o_data);
        end
        resetn = 1;
        model_reset();
        pix_q = '{32'hCAFEF00D};
        run_job(32'h3000, 1, 0, 100, 100, 0);
        check_plan_beats("after_reset", ed, ea);
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 6; i++) pix_q.push_back($urandom());
            run_job($urandom() & 32'hFFFFFFFC, 6, 0, 100, 100, 0);
        end
    endtask

    task automatic test_random();
        int cnt;
        for (int j = 0; j < 10; j++) begin
            cnt = $urandom_range(40);
            for (int i = 0; i < cnt + 4; i++) pix_q.push_back($urandom());
            run_job($urandom(), cnt, $urandom_range(20), 30 + $urandom_range(70),
                    40 + $urandom_range(60), 10);
        end
    endtask

    initial begin
        resetn = 0; tb_start = 0; tb_base = '0; tb_count = '0;
        tb_vin = 0; tb_px = '0; tb_ready = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_zero_and_extra();
        test_addr_wrap();
        test_reset_mid_job();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/painterengine_gpu_blend_writeback.md
Name: painterengine_gpu_blend_writeback

Overview:
Sink-side endpoint for the alpha-blend pipeline's output stream (a/r/g/b plus i_wire_valid, no backpressure).
- Packs each blended pixel into a 32-bit ARGB word and buffers it in a small FIFO.
- Emits address/data write beats with a valid/ready handshake toward the framebuffer memory writer.
- Frames one job of N pixels starting at a base address and pulses done when every pixel has left the block.

Parameters:
FIFO_DEPTH, 16, buffer entries; power of two, >=2
COUNT_WIDTH, 24, width of pixel-count and progress counters

Ports:
i_wire_clock  in  1  clock; all logic on rising edge
i_wire_resetn  in  1  synchronous active-low reset
i_wire_start  in  1  one-cycle job start, honoured only in IDLE
i_wire_base_address  in  32  byte address of first pixel, latched at start
i_wire_pixel_count  in  COUNT_WIDTH  pixels in job, latched at start
i_wire_valid  in  1  blended pixel present on a/r/g/b this cycle
a  in  8  blended alpha
r  in  8  blended red
g  in  8  blended green
b  in  8  blended blue
o_wire_valid  out  1  write beat valid
i_wire_ready  in  1  memory writer accepts beat
o_wire_address  out  32  beat byte address
o_wire_data  out  32  beat data {a,r,g,b}, a in [31:24], b in [7:0]
o_wire_busy  out  1  job in progress
o_wire_done  out  1  one-cycle pulse at job completion
o_wire_overflow  out  1  sticky: a pixel was dropped because the FIFO was full

Behaviour:
- Reset (i_wire_resetn=0 at a clock edge): state IDLE; FIFO emptied; counters cleared; all outputs 0. Applies mid-job; in-flight data is discarded with no done pulse.
- States: IDLE -> RUN -> FINISH -> IDLE.
- IDLE:
  - o_wire_busy=0; i_wire_valid is ignored.
  - On i_wire_start: latch base and count, clear accepted/written counters and overflow, go to RUN. o_wire_busy=1 from the next cycle.
  - If the latched count is 0, go directly to FINISH.
- RUN, input side:
  - If i_wire_valid and accepted<count: accepted++.
  - Push {a,r,g,b} if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise drop the pixel and set o_wire_overflow. A dropped pixel still counts as accepted.
  - Pixels arriving when accepted==count are ignored and do not set overflow.
- Output side (RUN and FINISH):
  - o_wire_valid = FIFO non-empty; o_wire_data = FIFO head.
  - o_wire_address = base + 4*written, modulo 2^32.
  - Beat transfers when o_wire_valid && i_wire_ready: pop, written++.
  - While valid && !ready, address and data hold stable.
- Latency: a pixel accepted into an empty FIFO at edge N appears on o_wire_data/o_wire_valid after edge N (one-cycle latency).
- RUN -> FINISH when accepted==count (evaluated after the current cycle's updates).
- FINISH:
  - Wait until the FIFO is empty.
  - On the cycle it is empty, pulse o_wire_done=1 for one cycle, drop o_wire_busy to 0 and return to IDLE.
  - For count=0, done pulses one cycle after entering FINISH.
- i_wire_start outside IDLE is ignored. A start in the same cycle as the done pulse is ignored; a new start is accepted from the following cycle.
- o_wire_overflow remains set after done until the next accepted start or reset.
- FIFO full/empty use a depth counter of log2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Basic job: base=0x1000, count=3, pixels (a,r,g,b)=(0x80,0xC0,0x80,0x1C),(0x80,0x57,0x44,0x37),(0x40,0x40,0x40,0x40) on consecutive cycles, ready=1 -> beats 0x80C0801C@0x1000, 0x80574437@0x1004, 0x40404040@0x1008; one done pulse; overflow=0.
- Backpressure: same job, ready=0 for 5 cycles then 1 -> o_wire_valid held; address 0x1000 and data stable during stall; all 3 beats delivered in order; then done.
- Overflow: FIFO_DEPTH=16, count=20, ready=0 while 20 pixels stream in, then ready=1 -> exactly 16 beats at 0x0..0x3C; overflow=1; done after the 16th beat.
- Zero count / extra input: count=0 -> done pulse, no beats. Then count=2 with 4 valid pixels -> only the first 2 written; overflow stays 0.
- Address wrap: base=0xFFFFFFFC, count=2 -> addresses 0xFFFFFFFC then 0x00000000.
- Reset mid-job: assert resetn=0 after 2 of 5 pixels -> the next cycle shows all outputs 0 and busy=0. A new start with count=1 completes normally.
